// File: rtl/ar_tx_scheduler.sv
// ar_tx_scheduler: shares one ARINC429 transmitter between NREQ word sources.
// Sources are served round-robin. The winner's label and data are latched,
// st is strobed once, and the word slot (32 bits + GAP_BITS idle bits at the
// selected rate) is timed locally because the transmitter reports no busy.
module ar_tx_scheduler #(
    parameter int NREQ       = 4,
    parameter int BIT_CYC_LS = 4000,
    parameter int BIT_CYC_MS = 1000,
    parameter int BIT_CYC_HS = 500,
    parameter int GAP_BITS   = 4,
    parameter int CW         = 20,
    localparam int IW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [1:0]           nvel_cfg,
    input  logic [NREQ-1:0]      req,
    input  logic [8*NREQ-1:0]    adr_in,
    input  logic [23*NREQ-1:0]   dat_in,
    output logic [NREQ-1:0]      gnt,
    output logic [1:0]           nvel,
    output logic [7:0]           adr,
    output logic [22:0]          dat,
    output logic                 st,
    output logic                 busy,
    output logic [IW-1:0]        cur_src
);

    // Slot lengths are fixed by the parameters, one per rate; the counter is
    // loaded with length-1 so that it reaches zero on the slot's last cycle.
    // CW must be wide enough for the low-speed slot.
    localparam logic [CW-1:0] SLOT_LS = CW'((32 + GAP_BITS) * BIT_CYC_LS - 1);
    localparam logic [CW-1:0] SLOT_MS = CW'((32 + GAP_BITS) * BIT_CYC_MS - 1);
    localparam logic [CW-1:0] SLOT_HS = CW'((32 + GAP_BITS) * BIT_CYC_HS - 1);
    localparam logic [IW-1:0] LAST_SRC = IW'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        WAIT   = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   ptr;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   slot_len;
    logic            win_found;
    logic [IW-1:0]   win_idx;
    logic [7:0]      win_adr;
    logic [22:0]     win_dat;
    logic [IW-1:0]   next_ptr;
    logic            grant_go;

    // Round-robin scan: first requester at or after ptr, wrapping at NREQ-1
    // (not at the next power of two).
    always_comb begin
        int            idx;
        logic [IW-1:0] idx_w;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        idx_w     = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            idx_w = IW'(idx);
            if (!win_found && req[idx_w]) begin
                win_found = 1'b1;
                win_idx   = idx_w;
            end
        end
    end

    // Select the winner's label/data, the slot length for the latched rate,
    // and the pointer value that follows the source just served.
    always_comb begin
        win_adr  = adr_in[int'(win_idx)*8 +: 8];
        win_dat  = dat_in[int'(win_idx)*23 +: 23];
        next_ptr = (cur_src == LAST_SRC) ? '0 : cur_src + 1'b1;
        case (nvel)
            2'b00:   slot_len = SLOT_LS;
            2'b01:   slot_len = SLOT_MS;
            default: slot_len = SLOT_HS;
        endcase
    end

    // Next-state logic: grant only from IDLE with en high; a started slot
    // always runs to completion regardless of en.
    always_comb begin
        state_nxt = state;
        grant_go  = 1'b0;
        case (state)
            IDLE: begin
                if (en && win_found) begin
                    grant_go  = 1'b1;
                    state_nxt = STROBE;
                end
            end
            STROBE: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Outputs, slot counter and arbitration pointer. gnt and st are
    // single-cycle pulses; st fires the cycle after gnt so that adr/dat/nvel
    // are already stable at the transmitter when it sees the strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt     <= '0;
            nvel    <= 2'b00;
            adr     <= 8'h00;
            dat     <= 23'h0;
            st      <= 1'b0;
            busy    <= 1'b0;
            cur_src <= '0;
            ptr     <= '0;
            cnt     <= '0;
        end else begin
            gnt <= '0;
            st  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_go) begin
                        adr     <= win_adr;
                        dat     <= win_dat;
                        nvel    <= nvel_cfg;
                        cur_src <= win_idx;
                        gnt     <= NREQ'(1) << win_idx;
                        busy    <= 1'b1;
                    end
                end
                STROBE: begin
                    st  <= 1'b1;
                    cnt <= slot_len;
                end
                WAIT: begin
                    if (cnt == '0) begin
                        busy <= 1'b0;
                        ptr  <= next_ptr;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule
